// File: rtl/buffer_write_multi_flow_if.sv
// Ingress stream, buffer write, used/freed pointer and status signals of buffer_write_multi_flow.
// The slave modport is the block itself, and the master modport is its environment.
interface buffer_write_multi_flow_if #(
   parameter int SEGMENT_SIZE_W = 10,
   parameter int BUF_SEG_AW     = 10,
   parameter int ADDR_WIDTH     = BUF_SEG_AW + SEGMENT_SIZE_W,
   parameter int FLOWS_W        = 3,
   parameter int DATA_W         = 64
);
   logic [DATA_W-1:0]     s_tdata;
   logic                  s_tvalid;
   logic                  s_tlast;
   logic [FLOWS_W-1:0]    s_tuser;
   logic                  s_tready;

   logic                  b_wen;
   logic [ADDR_WIDTH-1:0] b_waddr;
   logic [DATA_W-1:0]     b_wdata;

   logic [BUF_SEG_AW:0]   used_pointer;
   logic                  used_pointer_valid;
   logic [FLOWS_W-1:0]    used_pointer_flow;
   logic [BUF_SEG_AW-1:0] freed_pointer;
   logic                  freed_pointer_valid;

   logic                  init_done;
   logic [BUF_SEG_AW:0]   free_count;

   modport slave (
      input  s_tdata, s_tvalid, s_tlast, s_tuser, freed_pointer, freed_pointer_valid,
      output s_tready, b_wen, b_waddr, b_wdata, used_pointer, used_pointer_valid,
             used_pointer_flow, init_done, free_count
   );

   modport master (
      output s_tdata, s_tvalid, s_tlast, s_tuser, freed_pointer, freed_pointer_valid,
      input  s_tready, b_wen, b_waddr, b_wdata, used_pointer, used_pointer_valid,
             used_pointer_flow, init_done, free_count
   );
endinterface

// File: rtl/buffer_write_multi_flow.sv
// Writes multi-flow packets into a segmented buffer, drawing segments from an internal free list
// and reporting each filled segment as a used pointer tagged with the packet's flow.
module buffer_write_multi_flow #(
   parameter int SEGMENT_SIZE_W = 10,
   parameter int BUF_SEG_AW     = 10,
   parameter int ADDR_WIDTH     = BUF_SEG_AW + SEGMENT_SIZE_W,
   parameter int FLOWS_W        = 3,
   parameter int DATA_W         = 64
) (
   input logic                      clk,
   input logic                      rstn,
   buffer_write_multi_flow_if.slave bus
);

   localparam int unsigned NSEG = 2 ** BUF_SEG_AW;
   localparam logic [BUF_SEG_AW:0] FULL_CNT = {1'b1, {BUF_SEG_AW{1'b0}}};

   localparam logic [1:0] ST_INIT  = 2'd0;
   localparam logic [1:0] ST_FETCH = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_LOAD  = 2'd3;

   logic [1:0]                state_q, state_d;
   logic [BUF_SEG_AW-1:0]     wr_ptr_q;
   logic [BUF_SEG_AW-1:0]     rd_ptr_q;
   logic [BUF_SEG_AW:0]       count_q, count_d;
   logic [BUF_SEG_AW-1:0]     rd_data_q;
   logic [BUF_SEG_AW-1:0]     fl_mem [NSEG];
   logic                      init_done_q;

   logic [BUF_SEG_AW-1:0]     cur_seg_q;
   logic [SEGMENT_SIZE_W-1:0] offset_q;
   logic                      pkt_open_q;
   logic [FLOWS_W-1:0]        pkt_flow_q;

   logic                      b_wen_q;
   logic [ADDR_WIDTH-1:0]     b_waddr_q;
   logic [DATA_W-1:0]         b_wdata_q;
   logic                      up_valid_q;
   logic [BUF_SEG_AW:0]       up_q;
   logic [FLOWS_W-1:0]        up_flow_q;

   logic                      accept;
   logic                      seg_close;
   logic                      pop;
   logic                      init_push;
   logic                      free_push;
   logic                      push;
   logic [BUF_SEG_AW-1:0]     push_data;
   logic [FLOWS_W-1:0]        beat_flow;

   always_comb begin
      accept    = (state_q == ST_LOAD) && bus.s_tvalid;
      seg_close = accept && (bus.s_tlast || (&offset_q));
      pop       = (state_q == ST_FETCH) && (count_q != '0);
      init_push = (state_q == ST_INIT);
      free_push = bus.freed_pointer_valid && (state_q != ST_INIT);
      push      = init_push || (free_push && (count_q != FULL_CNT));
      // During INIT the write pointer walks 0..NSEG-1, so it doubles as the segment number pushed.
      push_data = init_push ? wr_ptr_q : bus.freed_pointer;
      beat_flow = pkt_open_q ? pkt_flow_q : bus.s_tuser;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_INIT:  if (&wr_ptr_q) state_d = ST_FETCH;
         ST_FETCH: if (pop)       state_d = ST_WAIT;
         ST_WAIT:                 state_d = ST_LOAD;
         ST_LOAD:  if (seg_close) state_d = ST_FETCH;
         default:                 state_d = ST_INIT;
      endcase
   end

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Free-list storage needs no reset; only its pointers and count define its contents.
   always_ff @(posedge clk) begin
      if (push) fl_mem[wr_ptr_q] <= push_data;
      if (pop)  rd_data_q <= fl_mem[rd_ptr_q];
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= ST_INIT;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         init_done_q <= 1'b0;
         cur_seg_q   <= '0;
         offset_q    <= '0;
         pkt_open_q  <= 1'b0;
         pkt_flow_q  <= '0;
         b_wen_q     <= 1'b0;
         b_waddr_q   <= '0;
         b_wdata_q   <= '0;
         up_valid_q  <= 1'b0;
         up_q        <= '0;
         up_flow_q   <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         if ((state_q == ST_INIT) && (&wr_ptr_q)) init_done_q <= 1'b1;

         if (state_q == ST_WAIT) begin
            cur_seg_q <= rd_data_q;
            offset_q  <= '0;
         end

         b_wen_q    <= accept;
         up_valid_q <= seg_close;
         if (accept) begin
            b_waddr_q  <= ADDR_WIDTH'({cur_seg_q, offset_q});
            b_wdata_q  <= bus.s_tdata;
            offset_q   <= offset_q + 1'b1;
            pkt_open_q <= !bus.s_tlast;
            if (!pkt_open_q) pkt_flow_q <= bus.s_tuser;
         end
         if (seg_close) begin
            up_q      <= {bus.s_tlast, cur_seg_q};
            up_flow_q <= beat_flow;
         end
      end
   end

   assign bus.s_tready           = (state_q == ST_LOAD);
   assign bus.b_wen              = b_wen_q;
   assign bus.b_waddr            = b_waddr_q;
   assign bus.b_wdata            = b_wdata_q;
   assign bus.used_pointer       = up_q;
   assign bus.used_pointer_valid = up_valid_q;
   assign bus.used_pointer_flow  = up_flow_q;
   assign bus.init_done          = init_done_q;
   assign bus.free_count         = count_q;

   a_no_overflow:  assert property (@(posedge clk) disable iff (!rstn) !(free_push && (count_q == FULL_CNT)));
   a_no_underflow: assert property (@(posedge clk) disable iff (!rstn) !(pop && (count_q == '0)));
   a_count_range:  assert property (@(posedge clk) disable iff (!rstn) (count_q <= FULL_CNT));

endmodule
